// File: rtl/rand_lfsr_queue.sv
// rand_lfsr_queue: reproducible pseudo-random word source (Galois LFSR) behind a DEPTH-entry response queue
//   CLK/RST               clock, async active-high reset
//   REQ_VALID/REQ_READY   request handshake, one word per accepted request
//   RESP_DATA/RESP_VALID/RESP_READY  queue head handshake
//   RESEED_VALID/RESEED_DATA  runtime LFSR reload (0 loads the effective seed)
//   COUNT                 queue occupancy
module rand_lfsr_queue #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS = 32'h80200003,
   parameter logic [WIDTH-1:0] SEED = 1,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   output logic [WIDTH-1:0] RESP_DATA,
   output logic             RESP_VALID,
   input  logic             RESP_READY,
   input  logic             RESEED_VALID,
   input  logic [WIDTH-1:0] RESEED_DATA,
   output logic [CW-1:0]    COUNT
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // an all-zero state would lock the LFSR, so a zero seed is promoted to 1
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
   logic [WIDTH-1:0] lfsr, step;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic push, pop;
   assign step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
   assign COUNT = count;
   assign RESP_VALID = count != '0;
   assign REQ_READY = count < CW'(DEPTH);
   assign RESP_DATA = mem[rd_ptr];
   assign push = REQ_VALID && REQ_READY;
   assign pop = RESP_VALID && RESP_READY;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lfsr <= SEED_EFF;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         // reseed overrides the step; a same-cycle push still takes the old state
         if (RESEED_VALID) lfsr <= (RESEED_DATA == '0) ? SEED_EFF : RESEED_DATA;
         else if (push) lfsr <= step;
         if (push) begin
            mem[wr_ptr] <= lfsr;
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_rand_lfsr_queue.sv
// tb_rand_lfsr_queue: directed checks of rand_lfsr_queue in an 8-bit/DEPTH=2 and a 32-bit/DEPTH=3 configuration
module tb_rand_lfsr_queue;
   logic clk = 0;
   always #5 clk = ~clk;
   int n_checks = 0, n_errors = 0;

   logic a_rst, a_req, a_ready, a_valid, a_rr, a_rsv;
   logic [7:0] a_data, a_rsd;
   logic [1:0] a_count;
   logic b_rst, b_req, b_ready, b_valid, b_rr, b_rsv;
   logic [31:0] b_data, b_rsd;
   logic [1:0] b_count;

   rand_lfsr_queue #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .DEPTH(2)) u_a (
      .CLK(clk), .RST(a_rst), .REQ_VALID(a_req), .REQ_READY(a_ready), .RESP_DATA(a_data),
      .RESP_VALID(a_valid), .RESP_READY(a_rr), .RESEED_VALID(a_rsv), .RESEED_DATA(a_rsd), .COUNT(a_count));
   rand_lfsr_queue #(.WIDTH(32), .DEPTH(3)) u_b (
      .CLK(clk), .RST(b_rst), .REQ_VALID(b_req), .REQ_READY(b_ready), .RESP_DATA(b_data),
      .RESP_VALID(b_valid), .RESP_READY(b_rr), .RESEED_VALID(b_rsv), .RESEED_DATA(b_rsd), .COUNT(b_count));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] step32(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
   endfunction

   logic [7:0] first_words [6] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
   logic [7:0] drain_words [3] = '{8'hB8, 8'h5C, 8'h2E};
   int seen [256];
   logic [31:0] q [$];
   logic [31:0] m;
   logic [7:0] w;
   logic acc, pp;
   int uniq;

   initial begin
      {a_req, a_rr, a_rsv, a_rsd, b_req, b_rr, b_rsv, b_rsd} = '0;
      a_rst = 1; b_rst = 1;
      repeat (2) tick();
      check("rst_valid", a_valid, 0);
      check("rst_count", a_count, 0);
      check("rst_ready", a_ready, 1);
      check("rst_data", a_data, 0);
      a_rst = 0; b_rst = 0;
      // first words, one per cycle with consumer always ready
      a_req = 1; a_rr = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("first_valid", a_valid, 1);
         check("first_data", a_data, first_words[i]);
      end
      a_req = 0;
      tick();
      check("first_empty", a_valid, 0);
      // fill to COUNT=2 then reset between edges
      a_req = 1; a_rr = 0;
      repeat (2) tick();
      check("full_count", a_count, 2);
      a_rst = 1;
      #2;
      check("async_valid", a_valid, 0);
      check("async_count", a_count, 0);
      check("async_ready", a_ready, 1);
      a_rst = 0;
      // backpressure from seed state
      tick();
      check("after_rst_data", a_data, 8'h01);
      tick();
      check("bp_count", a_count, 2);
      check("bp_ready", a_ready, 0);
      tick();
      check("bp_hold_count", a_count, 2);
      check("bp_head", a_data, 8'h01);
      a_rr = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_drain", a_data, drain_words[i]);
      end
      // full period of the 8-bit LFSR
      a_rst = 1;
      #2;
      a_rst = 0;
      a_req = 1; a_rr = 1;
      for (int i = 0; i < 256; i++) seen[i] = 0;
      for (int i = 1; i <= 256; i++) begin
         tick();
         w = a_data;
         if (i <= 255) seen[w]++;
      end
      a_req = 0;
      uniq = 0;
      for (int i = 1; i < 256; i++) if (seen[i] == 1) uniq++;
      check("period_unique", uniq, 255);
      check("period_zero", seen[0], 0);
      check("period_wrap", w, 8'h01);

      // reseed collision on the 32-bit instance
      b_req = 1; b_rr = 1; b_rsv = 1; b_rsd = 32'hDEADBEEF;
      tick();
      b_rsv = 0;
      check("reseed_old", b_data, 32'h00000001);
      tick();
      check("reseed_new", b_data, 32'hDEADBEEF);
      b_req = 0; b_rsv = 1; b_rsd = 0;
      tick();
      b_rsv = 0; b_req = 1;
      tick();
      check("reseed_zero", b_data, 32'h00000001);
      b_req = 0;
      tick();
      check("reseed_empty", b_valid, 0);

      // random traffic through the 3-entry queue against a model
      b_rst = 1;
      #2;
      b_rst = 0;
      m = 32'h1;
      for (int i = 0; i < 1000; i++) begin
         b_req = 1'($urandom);
         b_rr = 1'($urandom);
         acc = b_req && b_ready;
         pp = b_valid && b_rr;
         if (pp) begin
            check("wrap_data", b_data, (q.size() > 0) ? q[0] : 32'hx);
            if (q.size() > 0) void'(q.pop_front());
         end
         if (acc) begin
            q.push_back(m);
            m = step32(m);
         end
         tick();
         check("wrap_count", b_count, q.size());
         check("wrap_max", b_count <= 3, 1);
      end
      b_req = 0; b_rr = 1;
      for (int i = 0; i < 4; i++) begin
         if (b_valid && q.size() > 0) begin
            check("drain_data", b_data, q[0]);
            void'(q.pop_front());
         end
         tick();
      end
      check("drain_left", q.size(), 0);
      check("drain_valid", b_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
